quire_to_posit_4_0: RTL
=======================

# quire_to_posit_4_0

Converts the 20-bit quire produced by the posit<4,0> accumulator back into a 4-bit posit<4,0> pattern, with round-to-nearest-even, no underflow to zero and saturation to maxpos. It sits directly downstream of the accumulator and speaks the same rts/rtr/sow/eow streaming protocol on both sides. It is a 3-stage pipeline with a one-entry skid buffer, and can optionally emit only the end-of-window result.

## Interface
- EOW_ONLY, 1: if 1, only beats with eow_i=1 produce output; other beats are consumed and dropped. If 0, every beat produces output.
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rtr_o  out  1  ready to receive, registered
- rts_i  in  1  upstream ready to send
- sow_i  in  1  start of window
- eow_i  in  1  end of window
- data_i  in  20  quire, two's complement, value = data_i × 2^-4
- sign_i  in  1  quire sign (informative; data_i[19] is authoritative)
- zero_i  in  1  quire is zero
- NaR_i  in  1  quire is NaR
- rtr_i  in  1  downstream ready to receive
- rts_o  out  1  output beat valid
- sow_o, eow_o  out  1 each  window flags aligned with posit_o
- posit_o  out  4  encoded posit<4,0>
- sign_o  out  1  posit_o[3] when not NaR, else 0
- zero_o  out  1  posit_o==0000
- NaR_o  out  1  posit_o==1000
- inexact_o  out  1  rounding changed the value (not NaR/zero)

## Operation
- process_en = rtr_i | ~rts_o. rtr_o is process_en registered one cycle.
- A beat is transferred at any edge where rts_i & rtr_o = 1.
- A beat that arrives while process_en=0 goes to the skid register (1 entry). While the skid register is full, rtr_o=0. The skid beat enters stage 1 before any new beat. No beat is lost or duplicated.
- Stage 1 (capture):
  - Register sow, eow, NaR, zero and the sign s=data_i[19].
  - Compute m = |data_i| as a 20-bit unsigned value. -2^19 gives m=2^19.
  - With EOW_ONLY=1 and eow=0, the beat is marked a bubble.
- Stage 2 (round), m in units of 1/16:
  - 1–5 → 001
  - 6–10 → 010
  - 11–13 → 011
  - 14–20 → 100
  - 21–27 → 101
  - 28–48 → 110
  - ≥49 → 111
  - These ranges encode RNE ties: m=6 and m=10 go to 1/2; m=14 and m=20 go to 1; m=28 and m=48 go to 2.
  - inexact = m ∉ {4, 8, 12, 16, 24, 32, 64}.
- Stage 3 (encode):
  - p = {0, mag3}. posit = s ? (−p mod 16) : p.
  - NaR_i has priority and gives 1000.
  - Otherwise zero_i or m==0 gives 0000.
  - inexact=0 for NaR and zero.
- Stages advance only when process_en=1. Bubbles (invalid or dropped beats) clear the stage valid.
- Reset clears all valid bits, the skid register, rts_o, rtr_o, sow_o, eow_o, posit_o, sign_o, zero_o, NaR_o and inexact_o to 0. Reset asserted mid-operation discards all in-flight beats.

## Timing
- Latency: a beat accepted at edge k appears on rts_o after edge k+3, with no stall.
- Throughput: 1 beat/cycle while rtr_i=1.
- rtr_o first rises one cycle after rst deasserts.
- While rts_o=1 and rtr_i=0, all outputs hold stable. Output changes only after an edge where rtr_i=1.
- rtr_i drop → rtr_o drops one cycle later. At most one beat lands in skid in that cycle.
- rtr_i reassert → the skid beat drains first. rtr_o reasserts the cycle after the skid empties.
- A beat with sow_i=1 and eow_i=1 is a single-beat window. With EOW_ONLY=1 it is emitted.
- With EOW_ONLY=1, dropped beats still consume a transfer but create no rts_o pulse.

## Test plan
- Exact values, EOW_ONLY=0: data_i = 4, 8, 12, 16, 24, 32, 64 → posit_o = 0001…0111, inexact_o=0.
- Negative exact values: data_i = −16, 0xFFFF0 → 1100.
- Rounding and ties:
  - data_i = 6, 10, 14, 20, 28, 48 → posit_o = 0010, 0010, 0100, 0100, 0110, 0110, inexact_o=1.
  - data_i = 1 → 0001 (no underflow to zero).
  - data_i = 0x7FFFF → 0111.
  - data_i = 0x80000 → 1001.
- Specials, including priority:
  - NaR_i=1 with data_i=16 → posit_o = 1000, NaR_o=1.
  - zero_i=1 → 0000, zero_o=1.
  - NaR_i=1 and zero_i=1 → 1000.
- EOW_ONLY=1 window:
  - Input: 5 beats, sow on beat 0, eow on beat 4 (data_i=24).
  - Required: exactly one output beat, posit_o=0101, with sow_o=0 and eow_o=1.
- Backpressure:
  - Stimulus: continuous stream of 20 beats; rtr_i toggles 3 cycles low / 2 high.
  - Required: all 20 results appear in order, no loss or duplication, outputs stable while stalled.
  - Required: assert rst mid-stream → rts_o=0 on the next cycle and no stale beat after release.

Source files
------------

// File: rtl/quire_to_posit_4_0_if.sv
// Streaming rts/rtr/sow/eow bundle between the quire accumulator, the
// quire-to-posit<4,0> converter and its downstream consumer.
interface quire_to_posit_4_0_if;
    logic        rtr_o;
    logic        rts_i;
    logic        sow_i;
    logic        eow_i;
    logic [19:0] data_i;
    logic        sign_i;
    logic        zero_i;
    logic        NaR_i;
    logic        rtr_i;
    logic        rts_o;
    logic        sow_o;
    logic        eow_o;
    logic [3:0]  posit_o;
    logic        sign_o;
    logic        zero_o;
    logic        NaR_o;
    logic        inexact_o;

    modport slave (
        input  rts_i, sow_i, eow_i, data_i, sign_i, zero_i, NaR_i, rtr_i,
        output rtr_o, rts_o, sow_o, eow_o, posit_o, sign_o, zero_o, NaR_o, inexact_o
    );

    modport master (
        output rts_i, sow_i, eow_i, data_i, sign_i, zero_i, NaR_i, rtr_i,
        input  rtr_o, rts_o, sow_o, eow_o, posit_o, sign_o, zero_o, NaR_o, inexact_o
    );
endinterface

// File: rtl/quire_to_posit_4_0.sv
// Quire (20-bit, 2^-4 LSB) to posit<4,0> converter: RNE, no underflow to zero,
// saturation to maxpos; capture/round/encode stages plus output register and skid.
module quire_to_posit_4_0 #(
    parameter bit EOW_ONLY = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    quire_to_posit_4_0_if.slave  bus
);

    // Returns {inexact, mag3}; ranges already fold the round-to-nearest-even ties.
    function automatic logic [3:0] round_mag(input logic [19:0] m);
        logic [2:0] mag;
        logic       inx;
        if (m <= 20'd5)       mag = 3'd1;
        else if (m <= 20'd10) mag = 3'd2;
        else if (m <= 20'd13) mag = 3'd3;
        else if (m <= 20'd20) mag = 3'd4;
        else if (m <= 20'd27) mag = 3'd5;
        else if (m <= 20'd48) mag = 3'd6;
        else                  mag = 3'd7;
        case (m)
            20'd4, 20'd8, 20'd12, 20'd16, 20'd24, 20'd32, 20'd64: inx = 1'b0;
            default:                                               inx = 1'b1;
        endcase
        return {inx, mag};
    endfunction

    function automatic logic [3:0] encode(input logic s, input logic [2:0] mag);
        logic [3:0] p;
        p = {1'b0, mag};
        return s ? (~p + 4'd1) : p;
    endfunction

    logic        rtr_r, rts_r;
    logic        skid_v_r, skid_sow_r, skid_eow_r, skid_nar_r, skid_zero_r;
    logic [19:0] skid_data_r;
    logic        s1_v_r, s1_sow_r, s1_eow_r, s1_nar_r, s1_zero_r, s1_s_r;
    logic [19:0] s1_m_r;
    logic        s2_v_r, s2_sow_r, s2_eow_r, s2_nar_r, s2_zero_r, s2_s_r, s2_inexact_r;
    logic [2:0]  s2_mag_r;
    logic        s3_v_r, s3_sow_r, s3_eow_r, s3_inexact_r;
    logic [3:0]  s3_posit_r;
    logic        sow_r, eow_r, sign_r, zero_r, nar_r, inexact_r;
    logic [3:0]  posit_r;

    logic        accept_s, process_en_s, skid_next_s;
    logic        src_v_s, src_sow_s, src_eow_s, src_nar_s, src_zero_s, s1_v_s;
    logic [19:0] src_data_s, src_m_s;
    logic [3:0]  rnd_s, enc_posit_s;
    logic        enc_inexact_s;
    logic        unused_sign_s;

    assign unused_sign_s = bus.sign_i;

    // Source select (skid first), magnitude, rounding and encode datapath.
    always_comb begin
        accept_s     = bus.rts_i & rtr_r;
        process_en_s = bus.rtr_i | ~rts_r;
        skid_next_s  = process_en_s ? 1'b0 : (skid_v_r | accept_s);
        if (skid_v_r) begin
            src_v_s    = 1'b1;
            src_sow_s  = skid_sow_r;
            src_eow_s  = skid_eow_r;
            src_nar_s  = skid_nar_r;
            src_zero_s = skid_zero_r;
            src_data_s = skid_data_r;
        end else begin
            src_v_s    = accept_s;
            src_sow_s  = bus.sow_i;
            src_eow_s  = bus.eow_i;
            src_nar_s  = bus.NaR_i;
            src_zero_s = bus.zero_i;
            src_data_s = bus.data_i;
        end
        src_m_s = src_data_s[19] ? (~src_data_s + 20'd1) : src_data_s;
        s1_v_s  = src_v_s & ((EOW_ONLY == 1'b0) | src_eow_s);
        rnd_s   = round_mag(s1_m_r);
        if (s2_nar_r) begin
            enc_posit_s   = 4'b1000;
            enc_inexact_s = 1'b0;
        end else if (s2_zero_r) begin
            enc_posit_s   = 4'b0000;
            enc_inexact_s = 1'b0;
        end else begin
            enc_posit_s   = encode(s2_s_r, s2_mag_r);
            enc_inexact_s = s2_inexact_r;
        end
    end

    // Skid entry, pipeline stages and output registers; everything advances on process_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            rtr_r <= 1'b0; rts_r <= 1'b0;
            skid_v_r <= 1'b0; skid_sow_r <= 1'b0; skid_eow_r <= 1'b0;
            skid_nar_r <= 1'b0; skid_zero_r <= 1'b0; skid_data_r <= 20'd0;
            s1_v_r <= 1'b0; s1_sow_r <= 1'b0; s1_eow_r <= 1'b0; s1_nar_r <= 1'b0;
            s1_zero_r <= 1'b0; s1_s_r <= 1'b0; s1_m_r <= 20'd0;
            s2_v_r <= 1'b0; s2_sow_r <= 1'b0; s2_eow_r <= 1'b0; s2_nar_r <= 1'b0;
            s2_zero_r <= 1'b0; s2_s_r <= 1'b0; s2_inexact_r <= 1'b0; s2_mag_r <= 3'd0;
            s3_v_r <= 1'b0; s3_sow_r <= 1'b0; s3_eow_r <= 1'b0;
            s3_inexact_r <= 1'b0; s3_posit_r <= 4'd0;
            sow_r <= 1'b0; eow_r <= 1'b0; sign_r <= 1'b0; zero_r <= 1'b0;
            nar_r <= 1'b0; inexact_r <= 1'b0; posit_r <= 4'd0;
        end else begin
            rtr_r <= process_en_s & ~skid_next_s;
            if (process_en_s) begin
                skid_v_r     <= 1'b0;
                s1_v_r       <= s1_v_s;
                s1_sow_r     <= src_sow_s;
                s1_eow_r     <= src_eow_s;
                s1_nar_r     <= src_nar_s;
                s1_zero_r    <= src_zero_s;
                s1_s_r       <= src_data_s[19];
                s1_m_r       <= src_m_s;
                s2_v_r       <= s1_v_r;
                s2_sow_r     <= s1_sow_r;
                s2_eow_r     <= s1_eow_r;
                s2_nar_r     <= s1_nar_r;
                s2_zero_r    <= s1_zero_r | (s1_m_r == 20'd0);
                s2_s_r       <= s1_s_r;
                s2_inexact_r <= rnd_s[3];
                s2_mag_r     <= rnd_s[2:0];
                s3_v_r       <= s2_v_r;
                s3_sow_r     <= s2_sow_r;
                s3_eow_r     <= s2_eow_r;
                s3_inexact_r <= enc_inexact_s;
                s3_posit_r   <= enc_posit_s;
                rts_r        <= s3_v_r;
                sow_r        <= s3_sow_r;
                eow_r        <= s3_eow_r;
                posit_r      <= s3_posit_r;
                sign_r       <= s3_posit_r[3] & (s3_posit_r != 4'b1000);
                zero_r       <= (s3_posit_r == 4'b0000);
                nar_r        <= (s3_posit_r == 4'b1000);
                inexact_r    <= s3_inexact_r;
            end else if (accept_s) begin
                skid_v_r    <= 1'b1;
                skid_sow_r  <= bus.sow_i;
                skid_eow_r  <= bus.eow_i;
                skid_nar_r  <= bus.NaR_i;
                skid_zero_r <= bus.zero_i;
                skid_data_r <= bus.data_i;
            end else begin
                skid_v_r <= skid_v_r;
            end
        end
    end

    assign bus.rtr_o     = rtr_r;
    assign bus.rts_o     = rts_r;
    assign bus.sow_o     = sow_r;
    assign bus.eow_o     = eow_r;
    assign bus.posit_o   = posit_r;
    assign bus.sign_o    = sign_r;
    assign bus.zero_o    = zero_r;
    assign bus.NaR_o     = nar_r;
    assign bus.inexact_o = inexact_r;

endmodule
